seq_restoring_divider: RTL and testbench

//   Multi-cycle unsigned restoring divider: the inverse operation of the Wallace

---
 rtl/seq_restoring_divider.sv | 89 ++++++++
 tb/tb_seq_restoring_divider.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: multi-cycle unsigned restoring divider, one quotient bit per clock
//   clk, rst (async, active-high)
//   start, dividend, divisor          : request; operands sampled when accepted in IDLE
//   busy, done                        : handshake status decoded from the state register
//   quotient, remainder, div_by_zero  : registered results, held until the next accept
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] q, d;
    logic [WIDTH:0]   p, p_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH+1:0] p_sh, t;
    logic [WIDTH-1:0] q_n;
    logic             ge, last, accept;

    // Trial subtract on the shifted partial remainder; a set top bit of t is the borrow.
    assign p_sh   = {p, q[WIDTH-1]};
    assign t      = p_sh - {2'b00, d};
    assign ge     = ~t[WIDTH+1];
    assign p_n    = ge ? t[WIDTH:0] : p_sh[WIDTH:0];
    assign q_n    = {q[WIDTH-2:0], ge};
    assign last   = cnt == LAST;
    assign accept = state == IDLE && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state == IDLE ? (start ? (divisor != '0 ? RUN : DONE) : IDLE) :
                  state == RUN  ? (last ? DONE : RUN) : IDLE;
    end

    always_comb begin
        busy = state != IDLE;
        done = state == DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q           <= '0;
            d           <= '0;
            p           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            q   <= dividend;
            d   <= divisor;
            p   <= '0;
            cnt <= '0;
            // Divide by zero skips RUN; results are loaded now so they are valid in DONE.
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == RUN) begin
            q   <= q_n;
            p   <= p_n;
            cnt <= cnt + 1'b1;
            // Results are loaded on the final iteration so they are already valid while done is high.
            if (last) begin
                quotient    <= q_n;
                remainder   <= p_n[WIDTH-1:0];
                div_by_zero <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: self-checking bench for seq_restoring_divider (WIDTH=8)
module tb_seq_restoring_divider;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [W-1:0] dividend, divisor;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    logic         have_prev = 1'b0;
    logic [W-1:0] prev_q, prev_r;
    logic         prev_z;

    typedef struct {
        logic [W-1:0] a, b, q, r;
        logic         z;
    } vec_t;

    vec_t tbl[9];

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: plain arithmetic definition of unsigned division, all-ones/dividend on zero divisor.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] eq, output logic [W-1:0] er, output logic ez);
        ez = b == 0;
        eq = ez ? {W{1'b1}} : W'(int'(a) / int'(b));
        er = ez ? a : W'(int'(a) % int'(b));
    endtask

    // Waits (bounded) for done after an accept whose following negedge has just been reached (index 1).
    task automatic wait_done(input logic [W-1:0] b, output int lat, output logic busy_ok);
        lat = 1;
        busy_ok = 1'b1;
        while (!done && lat <= W + 3) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                                input int lat, input logic busy_ok);
        chk({tag, " latency"}, lat, (b == 0) ? 1 : W + 1);
        chk({tag, " busy_before_done"}, busy_ok, 1);
        chk({tag, " busy_at_done"}, busy, 1);
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
        chk({tag, " div_by_zero"}, div_by_zero, ez);
        if (b != 0) begin
            chk({tag, " invariant"}, int'(quotient) * int'(b) + int'(remainder), a);
            chk({tag, " rem_lt_div"}, remainder < b, 1);
        end
        have_prev = 1'b1;
        prev_q = eq;
        prev_r = er;
        prev_z = ez;
    endtask

    // Issues one operation in the cycle after the previous done, scrambles the inputs after accept.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
        int   lat;
        logic busy_ok;
        @(negedge clk);
        chk({tag, " idle_done"}, done, 0);
        chk({tag, " idle_busy"}, busy, 0);
        if (have_prev) begin
            chk({tag, " held_q"}, quotient, prev_q);
            chk({tag, " held_r"}, remainder, prev_r);
            chk({tag, " held_z"}, div_by_zero, prev_z);
        end
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(negedge clk);
        start = 1'b0;
        dividend = W'($urandom);
        divisor = W'($urandom);
        wait_done(b, lat, busy_ok);
        check_result(tag, a, b, eq, er, ez, lat, busy_ok);
    endtask

    function automatic logic [W-1:0] pick();
        int s;
        s = $urandom_range(0, 7);
        return s == 0 ? W'(0) : s == 1 ? W'(1) : s == 2 ? {W{1'b1}} : W'($urandom);
    endfunction

    initial begin
        int           lat;
        logic         busy_ok, saw_done;
        logic [W-1:0] a, b, eq, er;
        logic         ez;

        tbl[0] = '{a: 100, b: 7,   q: 14,  r: 2,   z: 0};
        tbl[1] = '{a: 255, b: 1,   q: 255, r: 0,   z: 0};
        tbl[2] = '{a: 5,   b: 9,   q: 0,   r: 5,   z: 0};
        tbl[3] = '{a: 37,  b: 0,   q: 255, r: 37,  z: 1};
        tbl[4] = '{a: 0,   b: 5,   q: 0,   r: 0,   z: 0};
        tbl[5] = '{a: 0,   b: 0,   q: 255, r: 0,   z: 1};
        tbl[6] = '{a: 255, b: 255, q: 1,   r: 0,   z: 0};
        tbl[7] = '{a: 254, b: 255, q: 0,   r: 254, z: 0};
        tbl[8] = '{a: 128, b: 16,  q: 8,   r: 0,   z: 0};

        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset quotient", quotient, 0);
        chk("reset remainder", remainder, 0);
        chk("reset dbz", div_by_zero, 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++)
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z);

        // A start while busy must be ignored and must not resample the operands.
        @(negedge clk);
        start = 1'b1;
        dividend = 200;
        divisor = 3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        dividend = 9;
        divisor = 2;
        @(negedge clk);
        start = 1'b0;
        lat = 4;
        busy_ok = 1'b1;
        while (!done && lat <= W + 3) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        check_result("ignored_start", 200, 3, 66, 2, 0, lat, busy_ok);
        run_op("after_ignored", 9, 2, 4, 1, 0);

        // Reset in the middle of RUN aborts the operation and clears everything immediately.
        @(negedge clk);
        start = 1'b1;
        dividend = 100;
        divisor = 7;
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort quotient", quotient, 0);
        chk("abort remainder", remainder, 0);
        chk("abort dbz", div_by_zero, 0);
        saw_done = 1'b0;
        repeat (W + 2) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst = 1'b0;
        chk("abort no_done", saw_done, 0);
        have_prev = 1'b1;
        prev_q = '0;
        prev_r = '0;
        prev_z = 1'b0;
        run_op("after_abort", 100, 7, 14, 2, 0);

        for (int i = 0; i < 1500; i++) begin
            a = pick();
            b = pick();
            model(a, b, eq, er, ez);
            run_op($sformatf("rand%0d_%0d/%0d", i, a, b), a, b, eq, er, ez);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
